// File: rtl/kuyruk_pkg.sv
// Shared field layout, widths and FSM encoding for the queue word builder
// and the downstream queue controller, so slot positions cannot diverge.
package kuyruk_pkg;

  localparam int GIRDI_SAYISI = 4;
  localparam int VERI_W       = 5;
  localparam int CEVRIM_W     = 3;
  localparam int GIRDI_W      = VERI_W + CEVRIM_W;
  localparam int KUYRUK_W     = GIRDI_SAYISI * GIRDI_W;

  typedef struct packed {
    logic [VERI_W-1:0]   veri;
    logic [CEVRIM_W-1:0] cevrim;
  } kuyruk_girdi_t;

  typedef enum logic [1:0] {
    BOS    = 2'd0,
    DOLDUR = 2'd1,
    GONDER = 2'd2
  } olusturucu_durum_t;

  // Slot 0 occupies the most significant bits of the word.
  function automatic logic [KUYRUK_W-1:0] slot_yaz(
    input logic [KUYRUK_W-1:0] kelime,
    input logic [2:0]          idx,
    input kuyruk_girdi_t       girdi
  );
    logic [KUYRUK_W-1:0] f;
    f = kelime;
    for (int i = 0; i < GIRDI_SAYISI; i++) begin
      if (3'(i) == idx) f[KUYRUK_W-1-i*GIRDI_W -: GIRDI_W] = girdi;
    end
    return f;
  endfunction

endpackage

// File: rtl/kuyruk_olusturucu.sv
// Packs (veri, cevrim) entries MSB-first into a queue word and hands it downstream.
// Optional build macro KUYRUK_SIFIR_CEVRIM_RED_EN: rejects cevrim==0 entries and pulses hata.
module kuyruk_olusturucu
  import kuyruk_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                giris_gecerli,
  output logic                giris_hazir,
  input  logic [VERI_W-1:0]   giris_veri,
  input  logic [CEVRIM_W-1:0] giris_cevrim,
  input  logic                bosalt,
  output logic                cikis_gecerli,
  input  logic                cikis_hazir,
  output logic [KUYRUK_W-1:0] cikis_kuyruk,
  output logic [2:0]          doluluk,
  output logic                hata
);

  olusturucu_durum_t   r_durum;
  logic [KUYRUK_W-1:0] r_kelime;
  logic [2:0]          r_sayac;

  logic                w_kabul;
  logic                w_yaz;
  logic [2:0]          w_sayac_art;

  assign w_kabul     = giris_gecerli && giris_hazir;
  assign w_sayac_art = r_sayac + 3'd1;

`ifdef KUYRUK_SIFIR_CEVRIM_RED_EN
  logic r_hata;
  logic w_red;

  assign w_red = w_kabul && (giris_cevrim == '0);
  assign w_yaz = w_kabul && !w_red;
  assign hata  = r_hata;

  always_ff @(posedge clk) begin
    if (rst) r_hata <= 1'b0;
    else     r_hata <= w_red;
  end
`else
  assign w_yaz = w_kabul;
  assign hata  = 1'b0;
`endif

  // Outputs come straight from registers; no path from cikis_hazir to giris_hazir.
  assign giris_hazir   = (r_durum != GONDER);
  assign cikis_gecerli = (r_durum == GONDER);
  assign cikis_kuyruk  = r_kelime;
  assign doluluk       = r_sayac;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_durum  <= BOS;
      r_kelime <= '0;
      r_sayac  <= '0;
    end else begin
      case (r_durum)
        BOS, DOLDUR: begin
          if (w_yaz) begin
            r_kelime <= slot_yaz(r_kelime, r_sayac, kuyruk_girdi_t'({giris_veri, giris_cevrim}));
            r_sayac  <= w_sayac_art;
            if ((w_sayac_art == 3'(GIRDI_SAYISI)) || bosalt) r_durum <= GONDER;
            else                                           r_durum <= DOLDUR;
          end else if (bosalt && (r_sayac != 3'd0)) begin
            r_durum <= GONDER;
          end
        end
        GONDER: begin
          // Release cycle takes no entry, so the next word starts clean.
          if (cikis_hazir) begin
            r_durum  <= BOS;
            r_kelime <= '0;
            r_sayac  <= '0;
          end
        end
        default: r_durum <= BOS;
      endcase
    end
  end

endmodule

// File: doc/kuyruk_olusturucu.md
Name: kuyruk_olusturucu

Overview:
- Upstream stage of the queue controller. Accepts (veri, cevrim) entries one per handshake and packs them MSB-first into a 32-bit queue word.
- Hands the word to the downstream controller over a valid/ready handshake.
- Emits a word when it is full, or early when the producer requests a flush.

Parameters:
- GIRDI_SAYISI, 4, entries per queue word.
- VERI_W, 5, data field width per entry.
- CEVRIM_W, 3, cycle-count field width per entry.
- Derived: GIRDI_W = VERI_W+CEVRIM_W = 8; KUYRUK_W = GIRDI_SAYISI*GIRDI_W = 32.

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  synchronous active-high reset
- giris_gecerli  input  1  entry valid
- giris_hazir  output  1  block can accept an entry
- giris_veri  input  VERI_W  entry data
- giris_cevrim  input  CEVRIM_W  entry cycle count
- bosalt  input  1  flush request: emit partial word
- cikis_gecerli  output  1  queue word valid
- cikis_hazir  input  1  downstream accepts word
- cikis_kuyruk  output  KUYRUK_W  packed queue word
- doluluk  output  3  entries currently packed, 0..GIRDI_SAYISI
- hata  output  1  one-cycle pulse on rejected entry (optional feature only)

Behaviour:
- Clocking and reset: one clock, clk; reset rst is synchronous and active-high.
- Reset values: all outputs 0, except giris_hazir=1; state BOS; internal word 0; slot counter 0.
  - Reset in any state, including GONDER mid-handshake, discards the word without emitting it.
- Entry format: slot i occupies bits [KUYRUK_W-1-i*GIRDI_W -: GIRDI_W] as {veri, cevrim}. Slot 0 is the MSBs, so entry 0 sits at veri [31:27] and cevrim [26:24]. Unused slots are 0.
- States:
  - BOS: empty, counter 0.
  - DOLDUR: 1..GIRDI_SAYISI-1 entries packed.
  - GONDER: word presented.
- giris_hazir = 1 in BOS and DOLDUR; 0 in GONDER (registered, no combinational path from cikis_hazir).
- Accept condition: giris_gecerli && giris_hazir. The entry is written to slot[counter] and the counter increments at that edge.
- BOS -> DOLDUR on accept.
- DOLDUR -> GONDER on either of:
  - an accept that fills the last slot;
  - bosalt=1.
- bosalt together with an accept: the entry is written first, then the block enters GONDER.
- bosalt in BOS (no entries): ignored, no empty word is ever emitted.
- Timing: cikis_gecerli rises the cycle after the triggering edge. cikis_kuyruk and doluluk are stable while cikis_gecerli=1.
- GONDER -> BOS on cikis_hazir=1; word and counter clear at that edge.
  - cikis_hazir=0 holds GONDER indefinitely.
  - No accept in the release cycle, so minimum word period is N+1 cycles.
- doluluk tracks the counter every cycle. In GONDER it equals the number of entries in the presented word.
- Input fields are taken verbatim; no arithmetic on cevrim. cevrim=0 entries are legal unless the optional feature is enabled.

Optional Feature:
- Macro KUYRUK_SIFIR_CEVRIM_RED_EN.
- Defined: an accepted handshake with giris_cevrim==0 is consumed but not written. Counter and state are unchanged, and hata pulses high for 1 cycle. If that cycle also carries bosalt with counter>0, the flush still proceeds.
- Undefined: cevrim=0 entries are packed normally and hata is tied to 0.
- The port list is identical in both builds.

Decomposition:
- Package kuyruk_pkg holds:
  - VERI_W, CEVRIM_W, GIRDI_W, KUYRUK_W, GIRDI_SAYISI;
  - the packed struct kuyruk_girdi_t {veri, cevrim};
  - the enum olusturucu_durum_t {BOS, DOLDUR, GONDER}.
- No sub-module: slot write and FSM fit in one module.
- The same package is shared with the downstream controller so field positions cannot diverge.

Test Plan:
- Fill: entries (1A,3), (01,1), (1F,7), (02,2) back-to-back -> next cycle cikis_gecerli=1, cikis_kuyruk=32'hD309FF12, doluluk=4, giris_hazir=0.
- Partial flush: (1A,3), (01,1), then bosalt -> cikis_kuyruk=32'hD3090000, doluluk=2. Then bosalt in BOS -> no cikis_gecerli.
- Backpressure: full word with cikis_hazir=0 for 3 cycles -> word stable, giris_hazir=0, entries offered are not taken. cikis_hazir=1 -> BOS next cycle, doluluk=0.
- Simultaneous: 3rd entry (1F,7) with bosalt -> word 32'hD309FF00, doluluk=3.
- Reset in GONDER: rst=1 one cycle -> cikis_gecerli=0, cikis_kuyruk=0, giris_hazir=1. The next entry lands in slot 0.
- With KUYRUK_SIFIR_CEVRIM_RED_EN: entry (05,0) -> hata=1 for one cycle, doluluk unchanged. Without the macro it packs as 8'h28.
